hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core; consumes the forwarding unit's load-use stall request together with branch redirects from EXE and wait signals from the instruction and data buses. Produces per-stage stall/flush (bubble) controls and the PC redirect. Holds a redirect that arrives while the pipeline is frozen and issues it once the pipeline can move.

---
 rtl/hazard_ctrl_pkg.sv | 40 ++++
 rtl/hazard_perf_cnt.sv | 44 ++++
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the RV32 hazard controller: stage indices, FSM encodings, control patterns.
// No logic, so no latency; no flow control.
// Imported by hazard_ctrl and hazard_perf_cnt.
package hazard_ctrl_pkg;

  localparam int NUM_STG = 5;

  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;

  localparam int HZ_STATE_WIDTH = 2;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_RUN        = 2'd0;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_WAIT       = 2'd1;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_REDIR_PEND = 2'd2;

  function automatic logic [NUM_STG-1:0] stg_bit(input int idx);
    logic [NUM_STG-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // A data-bus wait freezes everything up to EXE/MEM and bubbles MEM/WB so the
  // in-flight load/store is not retired twice.
  localparam logic [NUM_STG-1:0] STALL_MEMWAIT =
    stg_bit(STG_PC) | stg_bit(STG_IFID) | stg_bit(STG_IDEX) | stg_bit(STG_EXMEM);
  localparam logic [NUM_STG-1:0] FLUSH_MEMWAIT  = stg_bit(STG_MEMWB);

  localparam logic [NUM_STG-1:0] STALL_LOAD_USE = stg_bit(STG_PC) | stg_bit(STG_IFID);
  localparam logic [NUM_STG-1:0] FLUSH_LOAD_USE = stg_bit(STG_IDEX);

  localparam logic [NUM_STG-1:0] FLUSH_BRANCH   = stg_bit(STG_IFID) | stg_bit(STG_IDEX);

  localparam logic [NUM_STG-1:0] STALL_FETCH    = stg_bit(STG_PC);
  localparam logic [NUM_STG-1:0] FLUSH_FETCH    = stg_bit(STG_IFID);

endpackage

// File: rtl/hazard_perf_cnt.sv
// Hazard performance counters: stall cycles and redirects issued, wrapping.
// Counts visible one cycle after the incrementing event.
// No backpressure; increments are sampled every cycle.
module hazard_perf_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_inc_i,
  input  logic                 redir_inc_i,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (stall_inc_i) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redir_inc_i) begin
      redir_cnt_d = redir_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = redir_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush and PC redirect; counters under HAZARD_PERF_EN.
// Zero-cycle latency: controls are combinational from state and current inputs.
// Redirects arriving while frozen are held and issued once the pipeline can move.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_use_stall_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  if_busy_i,
  input  logic                  mem_busy_i,
  output logic [NUM_STG-1:0]    stall_o,
  output logic [NUM_STG-1:0]    flush_o,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0]  stall_cycles_o,
  output logic [CNT_WIDTH-1:0]  flush_count_o
);

  logic [HZ_STATE_WIDTH-1:0] state_q, state_d;
  logic                      pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]     pend_pc_q, pend_pc_d;

  logic [NUM_STG-1:0]        stall_raw, flush_raw;
  logic                      redir_raw;
  logic [ADDR_WIDTH-1:0]     redir_pc_raw;
  logic                      run_rules;

  always_comb begin
    stall_raw    = '0;
    flush_raw    = '0;
    redir_raw    = 1'b0;
    redir_pc_raw = '0;
    state_d      = state_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    run_rules    = 1'b0;

    case (state_q)
      HZ_RUN: begin
        run_rules = 1'b1;
      end

      HZ_WAIT: begin
        if (mem_busy_i) begin
          stall_raw = STALL_MEMWAIT;
          flush_raw = FLUSH_MEMWAIT;
          // Only the first branch of a freeze is kept; EXE is held, so any later
          // assertion is the same branch still sitting there.
          if (!pend_q && branch_taken_i) begin
            pend_d    = 1'b1;
            pend_pc_d = branch_target_i;
          end
        end else if (pend_q) begin
          flush_raw = FLUSH_BRANCH;
          pend_d    = 1'b0;
          if (if_busy_i) begin
            stall_raw = STALL_FETCH;
            state_d   = HZ_REDIR_PEND;
          end else begin
            redir_raw    = 1'b1;
            redir_pc_raw = pend_pc_q;
            state_d      = HZ_RUN;
          end
        end else begin
          run_rules = 1'b1;
        end
      end

      HZ_REDIR_PEND: begin
        if (mem_busy_i) begin
          stall_raw = STALL_MEMWAIT;
          flush_raw = FLUSH_MEMWAIT;
        end else if (if_busy_i) begin
          stall_raw = STALL_FETCH;
          flush_raw = FLUSH_FETCH;
        end else begin
          redir_raw    = 1'b1;
          redir_pc_raw = pend_pc_q;
          state_d      = HZ_RUN;
        end
      end

      default: begin
        state_d = HZ_RUN;
        pend_d  = 1'b0;
      end
    endcase

    if (run_rules) begin
      state_d = HZ_RUN;
      if (mem_busy_i) begin
        stall_raw = STALL_MEMWAIT;
        flush_raw = FLUSH_MEMWAIT;
        state_d   = HZ_WAIT;
        if (branch_taken_i) begin
          pend_d    = 1'b1;
          pend_pc_d = branch_target_i;
        end
      end else if (branch_taken_i) begin
        // The instruction behind the branch is wrong-path, so its load-use stall is moot.
        flush_raw = FLUSH_BRANCH;
        if (if_busy_i) begin
          stall_raw = STALL_FETCH;
          pend_pc_d = branch_target_i;
          state_d   = HZ_REDIR_PEND;
        end else begin
          redir_raw    = 1'b1;
          redir_pc_raw = branch_target_i;
        end
      end else if (load_use_stall_i) begin
        stall_raw = STALL_LOAD_USE;
        flush_raw = FLUSH_LOAD_USE;
      end else if (if_busy_i) begin
        stall_raw = STALL_FETCH;
        flush_raw = FLUSH_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HZ_RUN;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Controls are combinational, so they must be masked explicitly while in reset.
  assign stall_o       = rst_n ? stall_raw    : '0;
  assign flush_o       = rst_n ? flush_raw    : '0;
  assign redirect_o    = rst_n ? redir_raw    : 1'b0;
  assign redirect_pc_o = rst_n ? redir_pc_raw : '0;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_inc_i    (|stall_o),
    .redir_inc_i    (redirect_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a pending-redirect model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_use_stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        if_busy_i = 1'b0;
  logic        mem_busy_i = 1'b0;
  logic [4:0]  stall_o, flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o, stall_cycles_o, flush_count_o;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_use_stall_i (load_use_stall_i),
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .if_busy_i        (if_busy_i),
    .mem_busy_i       (mem_busy_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .redirect_o       (redirect_o),
    .redirect_pc_o    (redirect_pc_o),
    .stall_cycles_o   (stall_cycles_o),
    .flush_count_o    (flush_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: at most one outstanding redirect, remembered together with what is
  // holding it back (the data bus or the fetch bus).
  bit          m_has = 1'b0;
  bit          m_by_mem = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_redirs = '0;

  always @(negedge rst_n) begin
    m_has    = 1'b0;
    m_by_mem = 1'b0;
    m_pc     = '0;
    m_stalls = '0;
    m_redirs = '0;
  end

  always @(negedge clk) begin
    logic [4:0]  es, ef;
    logic        er;
    logic [31:0] ep;
    es = '0; ef = '0; er = 1'b0; ep = '0;
    if (rst_n) begin
      if (mem_busy_i) begin
        es = 5'b01111; ef = 5'b10000;
        if (!m_has && branch_taken_i) begin
          m_has = 1'b1; m_by_mem = 1'b1; m_pc = branch_target_i;
        end
      end else if (m_has && m_by_mem) begin
        ef = 5'b00110;
        if (if_busy_i) begin es = 5'b00001; m_by_mem = 1'b0; end
        else begin er = 1'b1; ep = m_pc; m_has = 1'b0; end
      end else if (m_has) begin
        if (if_busy_i) begin es = 5'b00001; ef = 5'b00010; end
        else begin er = 1'b1; ep = m_pc; m_has = 1'b0; end
      end else if (branch_taken_i) begin
        ef = 5'b00110;
        if (if_busy_i) begin
          es = 5'b00001; m_has = 1'b1; m_by_mem = 1'b0; m_pc = branch_target_i;
        end else begin
          er = 1'b1; ep = branch_target_i;
        end
      end else if (load_use_stall_i) begin
        es = 5'b00011; ef = 5'b00100;
      end else if (if_busy_i) begin
        es = 5'b00001; ef = 5'b00010;
      end
    end
    chk("model_stall", {27'd0, stall_o}, {27'd0, es});
    chk("model_flush", {27'd0, flush_o}, {27'd0, ef});
    chk("model_redirect", {31'd0, redirect_o}, {31'd0, er});
    chk("model_redirect_pc", redirect_pc_o, ep);
`ifdef HAZARD_PERF_EN
    chk("model_stall_cycles", stall_cycles_o, m_stalls);
    chk("model_flush_count", flush_count_o, m_redirs);
`else
    chk("model_stall_cycles", stall_cycles_o, 32'd0);
    chk("model_flush_count", flush_count_o, 32'd0);
`endif
    if (rst_n) begin
      if (es != 5'd0) m_stalls = m_stalls + 1;
      if (er) m_redirs = m_redirs + 1;
    end
  end

  // Applies inputs just after a rising edge and leaves time for outputs to settle.
  task automatic cyc(input logic lu, input logic bt, input logic [31:0] tgt,
                     input logic ifb, input logic memb);
    @(posedge clk);
    #1;
    load_use_stall_i = lu;
    branch_taken_i   = bt;
    branch_target_i  = tgt;
    if_busy_i        = ifb;
    mem_busy_i       = memb;
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] s, input logic [4:0] f,
                            input logic r, input logic [31:0] pc);
    chk({nm, "_stall"}, {27'd0, stall_o}, {27'd0, s});
    chk({nm, "_flush"}, {27'd0, flush_o}, {27'd0, f});
    chk({nm, "_redirect"}, {31'd0, redirect_o}, {31'd0, r});
    chk({nm, "_pc"}, redirect_pc_o, pc);
  endtask

  initial begin
    #2;
    load_use_stall_i = 1'b1;
    branch_taken_i   = 1'b1;
    branch_target_i  = 32'hDEAD_BEEF;
    mem_busy_i       = 1'b1;
    #1;
    expect_out("reset_hold", 5'b00000, 5'b00000, 1'b0, 32'h0);
    chk("reset_stall_cycles", stall_cycles_o, 32'd0);
    chk("reset_flush_count", flush_count_o, 32'd0);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 0, 32'h0, 0, 0);
    rst_n = 1'b1;

    cyc(0, 0, 32'h0, 0, 0);
    expect_out("idle", 5'b00000, 5'b00000, 1'b0, 32'h0);
    cyc(1, 0, 32'h0, 0, 0);
    expect_out("load_use", 5'b00011, 5'b00100, 1'b0, 32'h0);
    cyc(0, 0, 32'h0, 0, 0);
    expect_out("after_load_use", 5'b00000, 5'b00000, 1'b0, 32'h0);

    cyc(1, 1, 32'h0000_0100, 0, 0);
    expect_out("branch_now", 5'b00000, 5'b00110, 1'b1, 32'h0000_0100);
    cyc(0, 0, 32'h0, 0, 0);
    expect_out("branch_done", 5'b00000, 5'b00000, 1'b0, 32'h0);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h0000_0200, 0, 1);
      expect_out($sformatf("memwait%0d", i), 5'b01111, 5'b10000, 1'b0, 32'h0);
    end
    cyc(0, 1, 32'h0000_0200, 0, 0);
    expect_out("memwait_release", 5'b00000, 5'b00110, 1'b1, 32'h0000_0200);
    cyc(0, 0, 32'h0, 0, 0);
    expect_out("memwait_no_second", 5'b00000, 5'b00000, 1'b0, 32'h0);

    cyc(0, 1, 32'h0000_0300, 1, 0);
    expect_out("ifbusy_branch", 5'b00001, 5'b00110, 1'b0, 32'h0);
    cyc(0, 0, 32'h0, 1, 0);
    expect_out("ifbusy_hold", 5'b00001, 5'b00010, 1'b0, 32'h0);
    cyc(1, 1, 32'h0000_0999, 0, 0);
    expect_out("ifbusy_release", 5'b00000, 5'b00000, 1'b1, 32'h0000_0300);

    cyc(0, 1, 32'h0000_0400, 0, 1);
    cyc(0, 1, 32'h0000_0500, 0, 0);
    expect_out("first_branch_kept", 5'b00000, 5'b00110, 1'b1, 32'h0000_0400);

    cyc(0, 1, 32'h0000_0600, 0, 1);
    cyc(0, 0, 32'h0, 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("reset_in_wait", 5'b00000, 5'b00000, 1'b0, 32'h0);
    cyc(0, 0, 32'h0, 0, 0);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 32'h0, 0, 0);
    expect_out("after_reset_no_redirect", 5'b00000, 5'b00000, 1'b0, 32'h0);

    for (int i = 0; i < 4; i++) cyc(1, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h0000_0700, 0, 0);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h0000_0800, 0, 0);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 0, 32'h0, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cycles", stall_cycles_o, 32'd4);
    chk("perf_flush_count", flush_count_o, 32'd2);
`else
    chk("perf_stall_cycles", stall_cycles_o, 32'd0);
    chk("perf_flush_count", flush_count_o, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          $urandom & 32'hFFFF_FFFC,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 0, 32'h0, 0, 0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
